// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and width helpers.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    localparam int N_IN_MIN = 1;
    localparam int N_IN_MAX = 6;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int max_count);
        int w;
        w = clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/status and DUT-facing signals of the sweeper; slave = sweeper side.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
) ();
    localparam int TW = 1 << N_IN;

    logic            start;
    logic            abort;
    logic            f_in;
    logic [N_IN-1:0] a_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [TW-1:0]   truth_tbl;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, abort, f_in,
        input  a_out, busy, done, pass, truth_tbl, first_fail
    );

    modport slave (
        input  start, abort, f_in,
        output a_out, busy, done, pass, truth_tbl, first_fail
    );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter timing how long each code is held before sampling.
module truth_table_sweeper_settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int              CW     = cnt_width(SETTLE_CYC);
    localparam logic [CW-1:0]   RELOAD = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Held at the reload value while not settling, so the first settle cycle sees it.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input code into a small gate block, captures its truth table and grades it.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                   N_IN        = 3,
    parameter int                   SETTLE_CYC  = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED_TT = 8'h80
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave sw
);
    localparam int              TW       = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam sweep_state_e    ENTRY_ST = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [TW-1:0]   tbl_q, tbl_d;
    logic            pass_q, pass_d;
    logic [N_IN-1:0] ff_q, ff_d;

    logic            settle_expire;
    logic [TW-1:0]   cap_tbl;
    logic [TW-1:0]   miss;
    logic [N_IN-1:0] miss_idx;

    generate
        if (SETTLE_CYC > 0) begin : g_timer
            logic settle_load;
            assign settle_load = (state_q != ST_SETTLE);

            truth_table_sweeper_settle_timer #(
                .SETTLE_CYC (SETTLE_CYC)
            ) u_timer (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (settle_load),
                .expire (settle_expire)
            );
        end else begin : g_no_timer
            assign settle_expire = 1'b1;
        end
    endgenerate

    // Table as it would look after capturing f_in at the current index.
    generate
        for (genvar gi = 0; gi < TW; gi++) begin : g_cap
            assign cap_tbl[gi] = (idx_q == N_IN'(gi)) ? sw.f_in : tbl_q[gi];
        end
    endgenerate

    assign miss = cap_tbl ^ EXPECTED_TT;

    always_comb begin
        miss_idx = '0;
        for (int k = TW - 1; k >= 0; k--) begin
            if (miss[k]) begin
                miss_idx = N_IN'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tbl_d   = tbl_q;
        pass_d  = pass_q;
        ff_d    = ff_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
                if (sw.start && !sw.abort) begin
                    state_d = ENTRY_ST;
                    idx_d   = '0;
                    tbl_d   = '0;
                    pass_d  = 1'b0;
                    ff_d    = '0;
                end
            end
            ST_SETTLE: begin
                if (sw.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                end else if (settle_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // Abort beats both the capture and completion on the final code.
                if (sw.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    tbl_d = cap_tbl;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        pass_d  = (miss == '0);
                        ff_d    = miss_idx;
                    end else begin
                        state_d = ENTRY_ST;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tbl_q   <= '0;
            pass_q  <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tbl_q   <= tbl_d;
            pass_q  <= pass_d;
            ff_q    <= ff_d;
        end
    end

    assign sw.a_out      = idx_q;
    assign sw.busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign sw.done       = (state_q == ST_DONE);
    assign sw.pass       = pass_q;
    assign sw.truth_tbl  = tbl_q;
    assign sw.first_fail = ff_q;

endmodule
